// File: rtl/bus_dev_port_if.sv
// bus_dev_port_if: device/arbiter-side signals of one bus device port
interface bus_dev_port_if #(parameter int pckg_sz = 16);
    logic               wr_en;
    logic [pckg_sz-1:0] wr_data;
    logic               tx_full;
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;
    logic               rd_en;
    logic [pckg_sz-1:0] rd_data;
    logic               rx_empty;
    logic [7:0]         tx_drop_cnt;
    logic [7:0]         rx_drop_cnt;
    modport slave (
        input  wr_en, wr_data, pop, push, D_push, rd_en,
        output tx_full, pndng, D_pop, rd_data, rx_empty, tx_drop_cnt, rx_drop_cnt
    );
    modport master (
        output wr_en, wr_data, pop, push, D_push, rd_en,
        input  tx_full, pndng, D_pop, rd_data, rx_empty, tx_drop_cnt, rx_drop_cnt
    );
endinterface

// File: rtl/bus_dev_port.sv
// bus_dev_port: TX/RX show-ahead FIFO pair for one shared-bus device.
// BUS_DEV_ADDR_FILTER_EN: RX keeps only packets addressed to id or bcast.
module bus_dev_port #(
    parameter int         pckg_sz = 16,
    parameter int         depth   = 8,
    parameter logic [7:0] id      = 8'd0,
    parameter logic [7:0] bcast   = 8'hFF
) (
    input logic          clk,
    input logic          reset,
    bus_dev_port_if.slave bus
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(depth);

    logic [pckg_sz-1:0] tx_mem [depth];
    logic [pckg_sz-1:0] rx_mem [depth];
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [7:0]    tx_drop_q, tx_drop_d, rx_drop_q, rx_drop_d;
    logic tx_rd, tx_wr, rx_rd, rx_wr, rx_match;

    always_comb begin
`ifdef BUS_DEV_ADDR_FILTER_EN
        rx_match = (bus.D_push[pckg_sz-1 -: 8] == id) || (bus.D_push[pckg_sz-1 -: 8] == bcast);
`else
        rx_match = 1'b1;
`endif
        tx_rd     = bus.pop && tx_cnt_q != '0;
        tx_wr     = bus.wr_en && (tx_cnt_q != FULL || tx_rd);
        rx_rd     = bus.rd_en && rx_cnt_q != '0;
        rx_wr     = bus.push && rx_match && (rx_cnt_q != FULL || rx_rd);
        tx_wp_d   = tx_wr ? tx_wp_q + AW'(1) : tx_wp_q;
        tx_rp_d   = tx_rd ? tx_rp_q + AW'(1) : tx_rp_q;
        rx_wp_d   = rx_wr ? rx_wp_q + AW'(1) : rx_wp_q;
        rx_rp_d   = rx_rd ? rx_rp_q + AW'(1) : rx_rp_q;
        tx_cnt_d  = tx_cnt_q + CW'(tx_wr) - CW'(tx_rd);
        rx_cnt_d  = rx_cnt_q + CW'(rx_wr) - CW'(rx_rd);
        // drop counters stick at 255 rather than wrapping
        tx_drop_d = (bus.wr_en && !tx_wr && tx_drop_q != 8'hFF) ? tx_drop_q + 8'd1 : tx_drop_q;
        rx_drop_d = (bus.push && !rx_wr && rx_drop_q != 8'hFF) ? rx_drop_q + 8'd1 : rx_drop_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            tx_drop_q <= '0;
            rx_drop_q <= '0;
        end else begin
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_drop_q <= tx_drop_d;
            rx_drop_q <= rx_drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_wr) tx_mem[tx_wp_q] <= bus.wr_data;
        if (rx_wr) rx_mem[rx_wp_q] <= bus.D_push;
    end

    assign bus.tx_full     = tx_cnt_q == FULL;
    assign bus.pndng       = tx_cnt_q != '0;
    assign bus.rx_empty    = rx_cnt_q == '0;
    assign bus.D_pop       = bus.pndng ? tx_mem[tx_rp_q] : '0;
    assign bus.rd_data     = bus.rx_empty ? '0 : rx_mem[rx_rp_q];
    assign bus.tx_drop_cnt = tx_drop_q;
    assign bus.rx_drop_cnt = rx_drop_q;
endmodule

// File: tb/tb_bus_dev_port.sv
// tb_bus_dev_port: directed checks of bus_dev_port (depth 8, id 2).
module tb_bus_dev_port;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    bus_dev_port_if #(.pckg_sz(16)) bus ();
    bus_dev_port #(.pckg_sz(16), .depth(8), .id(8'd2), .bcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_q [8];
        bus.wr_en = 0; bus.wr_data = 0; bus.pop = 0;
        bus.push = 0; bus.D_push = 0; bus.rd_en = 0;
        #12;
        check("rst_pndng", bus.pndng, 0);
        check("rst_tx_full", bus.tx_full, 0);
        check("rst_rx_empty", bus.rx_empty, 1);
        check("rst_D_pop", bus.D_pop, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_tx_drop", bus.tx_drop_cnt, 0);
        check("rst_rx_drop", bus.rx_drop_cnt, 0);
        reset = 1;
        step();

        bus.wr_en = 1; bus.wr_data = 16'hA001;
        step();
        check("first_pndng", bus.pndng, 1);
        check("first_head", bus.D_pop, 16'hA001);
        bus.wr_data = 16'hA002; step();
        bus.wr_data = 16'hA003; step();
        bus.wr_en = 0; bus.pop = 1;
        check("pop1", bus.D_pop, 16'hA001);
        step();
        check("pop2", bus.D_pop, 16'hA002);
        step();
        check("pop3", bus.D_pop, 16'hA003);
        step();
        check("drained_pndng", bus.pndng, 0);

        step();
        check("empty_pop_pndng", bus.pndng, 0);
        check("empty_pop_D_pop", bus.D_pop, 0);
        check("empty_pop_full", bus.tx_full, 0);
        check("empty_pop_drop", bus.tx_drop_cnt, 0);
        bus.pop = 0;

        bus.wr_en = 1;
        for (int i = 0; i < 8; i++) begin
            bus.wr_data = 16'hB000 + 16'(i);
            step();
        end
        check("fill_full", bus.tx_full, 1);
        check("fill_head", bus.D_pop, 16'hB000);
        bus.wr_data = 16'hC009; step();
        check("ninth_drop", bus.tx_drop_cnt, 1);
        check("ninth_full", bus.tx_full, 1);
        check("ninth_head", bus.D_pop, 16'hB000);
        bus.pop = 1; bus.wr_data = 16'hC00A; step();
        bus.wr_en = 0;
        check("tenth_full", bus.tx_full, 1);
        check("tenth_head", bus.D_pop, 16'hB001);
        check("tenth_drop", bus.tx_drop_cnt, 1);
        exp_q = '{16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hB005, 16'hB006, 16'hB007, 16'hC00A};
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d", i), bus.D_pop, exp_q[i]);
            step();
        end
        bus.pop = 0;
        check("drain_pndng", bus.pndng, 0);

        bus.push = 1;
        bus.D_push = 16'h0211; step();
        bus.D_push = 16'hFF22; step();
        bus.D_push = 16'h0533; step();
        bus.push = 0;
        check("rx_head", bus.rd_data, 16'h0211);
        bus.rd_en = 1; step();
        check("rx_second", bus.rd_data, 16'hFF22);
        step();
`ifdef BUS_DEV_ADDR_FILTER_EN
        check("rx_filter_drop", bus.rx_drop_cnt, 1);
        check("rx_filter_empty", bus.rx_empty, 1);
`else
        check("rx_nofilter_drop", bus.rx_drop_cnt, 0);
        check("rx_third", bus.rd_data, 16'h0533);
        step();
        check("rx_nofilter_empty", bus.rx_empty, 1);
`endif
        bus.rd_en = 0;

        bus.push = 1;
        for (int i = 0; i < 300; i++) begin
            bus.D_push = 16'h0200 + 16'(i[7:0]);
            step();
        end
        check("rx_sat", bus.rx_drop_cnt, 255);
        check("rx_sat_head", bus.rd_data, 16'h0200);
        bus.rd_en = 1; bus.D_push = 16'h02AA; step();
        bus.push = 0; bus.rd_en = 0;
        check("rx_full_rw_drop", bus.rx_drop_cnt, 255);
        check("rx_full_rw_head", bus.rd_data, 16'h0201);

        bus.wr_en = 1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_data = 16'hD001 + 16'(i);
            step();
        end
        bus.wr_en = 0;
        #3 reset = 0;
        #1;
        check("async_pndng", bus.pndng, 0);
        check("async_full", bus.tx_full, 0);
        check("async_rx_empty", bus.rx_empty, 1);
        check("async_D_pop", bus.D_pop, 0);
        check("async_rd_data", bus.rd_data, 0);
        check("async_tx_drop", bus.tx_drop_cnt, 0);
        check("async_rx_drop", bus.rx_drop_cnt, 0);
        step();
        reset = 1;
        #2;
        bus.wr_en = 1; bus.wr_data = 16'hE001; step();
        bus.wr_en = 0;
        check("post_rst_pndng", bus.pndng, 1);
        check("post_rst_head", bus.D_pop, 16'hE001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_dev_port.md
# bus_dev_port

Device-side port FIFO pair for the shared-bus generator/arbiter. One instance per device: the TX FIFO holds packets the device wants to send and presents them to the arbiter through `pndng`/`D_pop`/`pop`; the RX FIFO captures packets the arbiter delivers through `push`/`D_push`. It replaces the behavioural FIFO model in the bus testbench drivers with synthesizable RTL.

## Interface
- `pckg_sz`, 16: packet width in bits; the top 8 bits are the destination address.
- `depth`, 8: entries per FIFO, a power of two ≥ 2.
- `id`, 0: this device's bus address (8 bits).
- `bcast`, 8'hFF: broadcast address.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `wr_en`  in  1  device writes `wr_data` into TX FIFO.
- `wr_data`  in  pckg_sz  packet from device.
- `tx_full`  out  1  TX FIFO holds `depth` entries.
- `pndng`  out  1  TX FIFO non-empty (to arbiter).
- `D_pop`  out  pckg_sz  TX head packet, valid when `pndng`=1.
- `pop`  in  1  arbiter consumes TX head.
- `push`  in  1  arbiter delivers `D_push`.
- `D_push`  in  pckg_sz  delivered packet.
- `rd_en`  in  1  device consumes RX head.
- `rd_data`  out  pckg_sz  RX head, valid when `rx_empty`=0.
- `rx_empty`  out  1  RX FIFO empty.
- `tx_drop_cnt`  out  8  writes rejected because TX was full, saturating.
- `rx_drop_cnt`  out  8  pushes rejected (RX full or filtered), saturating.

## Operation
- Each FIFO is a circular buffer: read and write pointers of `$clog2(depth)` bits wrapping modulo `depth`, plus an occupancy counter of `$clog2(depth)+1` bits.
- Heads are show-ahead: `D_pop` and `rd_data` are combinational from the head entry. When empty, they drive 0.
- TX write is accepted if `wr_en` and (not full, or `pop` with `pndng`=1 in the same cycle). Otherwise the packet is dropped and `tx_drop_cnt` increments.
- TX pop is honored only when `pndng`=1. A `pop` while empty is ignored and has no other effect.
- RX push follows the same rules mirrored: `push`/`D_push` write, `rd_en` reads. A full RX still accepts a push if `rd_en` is high with `rx_empty`=0 in the same cycle. Otherwise the push is dropped and `rx_drop_cnt` increments.
- A simultaneous accepted write and read leaves occupancy unchanged and moves both pointers.
- Drop counters saturate at 255 and never wrap.
- Reset values: all pointers and counts are 0. `pndng`=0, `tx_full`=0, `rx_empty`=1, `D_pop`=0, `rd_data`=0, both drop counters 0. Array contents are don't-care.
- A reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.

## Timing
- Write-to-visible latency is 1 cycle. A packet written at edge N appears on `D_pop`/`pndng` (or `rd_data`/`rx_empty`) after edge N.
- Pop/read takes effect at the edge where it is sampled. The next head appears in the same post-edge cycle.
- `tx_full`, `pndng` and `rx_empty` are derived from the registered counts and are glitch-free with respect to the inputs.
- Drop counters update at the edge where the drop occurs.

## Configuration
- `BUS_DEV_ADDR_FILTER_EN` defined:
  - RX accepts a push only if `D_push[pckg_sz-1 -: 8]` equals `id` or `bcast`.
  - A non-matching push is dropped and counted in `rx_drop_cnt`.
- Undefined: every push is accepted subject only to capacity. The address field is ignored.

## Test plan
- Reset, then write 0xA001, 0xA002, 0xA003 with `pop` low:
  - `pndng`=1 one cycle after the first write, and `D_pop`=0xA001.
  - Three pops return 0xA001, 0xA002, 0xA003 in order.
  - `pndng`=0 after the third pop.
- Fill TX with `depth`=8 writes:
  - `tx_full`=1.
  - A ninth write with `pop` low is dropped and `tx_drop_cnt`=1.
  - A tenth write with `pop` high is accepted: `tx_full` stays 1 and the head advances.
- Pop with TX empty: no state change, `pndng`=0, `D_pop`=0.
- With `BUS_DEV_ADDR_FILTER_EN` and `id`=2:
  - Pushing 0x0211 is stored.
  - Pushing 0xFF22 is stored.
  - Pushing 0x0533 is dropped, giving `rx_drop_cnt`=1.
  - Reads return 0x0211 then 0xFF22.
  - Without the macro, all three packets are stored.
- Perform 300 pushes into a full RX with `rd_en` low: `rx_drop_cnt` saturates at 255.
- Write 3 packets, then assert `reset` low between clock edges:
  - `pndng`=0, `tx_full`=0, `rx_empty`=1 and the counters are 0 immediately.
  - After release, a new write appears as the head.
